// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter
// Write-port arbiter for the 32x32 register file. It merges three result
// producers into the file's single write port:
//   - ALU : single-cycle, no backpressure, always owns the slot when valid.
//   - LSU : valid/ready, buffered in a shared FIFO.
//   - MD  : valid/ready, buffered in the same shared FIFO.
// FIFO entries drain into write slots the ALU leaves free. A pending-write
// mask tells decode which registers still have queued results. A starve
// counter raises drain_req when the ALU keeps the FIFO head blocked.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   alu_valid/alu_reg_id/alu_data   ALU result (always accepted)
//   lsu_valid/lsu_ready/lsu_reg_id/lsu_data   LSU result handshake
//   md_valid/md_ready/md_reg_id/md_data       mul/div result handshake
//   write_reg_id/enable/data        registered register-file write port
//   pending_mask                    bit n set: a queued entry targets rN
//   drain_req                       ask the core for an ALU bubble
module reg_writeback_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg_id,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_reg_id,
  input  logic [31:0] lsu_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_reg_id,
  input  logic [31:0] md_data,
  output logic [4:0]  write_reg_id,
  output logic        write_reg_enable,
  output logic [31:0] write_reg_data,
  output logic [31:0] pending_mask,
  output logic        drain_req
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  // Round-robin pointer: which enqueue requester wins a tie.
  typedef enum logic {
    RR_LSU = 1'b0,
    RR_MD  = 1'b1
  } rr_e;

  rr_e rr_q, rr_d;

  logic [4:0]       fifo_id   [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       starve_cnt, starve_next;

  logic        full, empty, contend;
  logic        lsu_fire, md_fire, push, pop;
  logic [4:0]  push_id;
  logic [31:0] push_data;
  logic [PTR_W-1:0] scan_idx;

  // Enqueue arbitration. Readies come only from registered state (count and
  // RR pointer) plus the valids, so a pop in the same cycle never frees a slot
  // early: a full FIFO refuses both producers for that cycle.
  always_comb begin
    full      = (count == FULL_COUNT);
    empty     = (count == '0);
    contend   = lsu_valid && md_valid;
    lsu_ready = !full && !(contend && (rr_q == RR_MD));
    md_ready  = !full && !(contend && (rr_q == RR_LSU));
    lsu_fire  = lsu_valid && lsu_ready;
    md_fire   = md_valid && md_ready;
    push_id   = lsu_fire ? lsu_reg_id : md_reg_id;
    push_data = lsu_fire ? lsu_data : md_data;
    // A result for r0 completes its handshake but is dropped here.
    push      = (lsu_fire || md_fire) && (push_id != 5'd0);
    pop       = !alu_valid && !empty;
  end

  // Next RR pointer: after a contended grant, favour the loser next time.
  always_comb begin
    rr_d = rr_q;
    if (!full && contend) begin
      rr_d = (rr_q == RR_LSU) ? RR_MD : RR_LSU;
    end
  end

  // Starve counter: counts cycles the ALU holds off a non-empty FIFO, and
  // resets as soon as the head is popped or nothing is queued.
  always_comb begin
    starve_next = starve_cnt;
    if (pop || empty) begin
      starve_next = 8'd0;
    end else if (alu_valid && (starve_cnt != STARVE_MAX)) begin
      starve_next = starve_cnt + 8'd1;
    end
  end

  // Pending mask: OR of the one-hot ids of every occupied FIFO slot, scanned
  // from the head. r0 can never be queued, but bit 0 is forced low anyway.
  always_comb begin
    pending_mask = 32'd0;
    scan_idx     = rd_ptr;
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      scan_idx = rd_ptr + PTR_W'(j);
      if (CNT_W'(j) < count) begin
        pending_mask[fifo_id[scan_idx]] = 1'b1;
      end
    end
    pending_mask[0] = 1'b0;
  end

  // FIFO storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_id[wr_ptr]   <= push_id;
      fifo_data[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers, count, RR pointer and starve tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      rr_q       <= RR_LSU;
      starve_cnt <= 8'd0;
      drain_req  <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      starve_cnt <= starve_next;
      drain_req  <= (starve_next == STARVE_MAX);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port. The ALU always wins the slot; an ALU write to r0
  // still consumes the slot but is suppressed. Otherwise the FIFO head drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_reg_id     <= 5'd0;
      write_reg_enable <= 1'b0;
      write_reg_data   <= 32'd0;
    end else if (alu_valid) begin
      write_reg_id     <= alu_reg_id;
      write_reg_enable <= (alu_reg_id != 5'd0);
      write_reg_data   <= alu_data;
    end else if (pop) begin
      write_reg_id     <= fifo_id[rd_ptr];
      write_reg_enable <= 1'b1;
      write_reg_data   <= fifo_data[rd_ptr];
    end else begin
      write_reg_id     <= 5'd0;
      write_reg_enable <= 1'b0;
      write_reg_data   <= 32'd0;
    end
  end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// tb_reg_writeback_arbiter
// Directed bench for reg_writeback_arbiter (FIFO_DEPTH=4, STARVE_LIMIT=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there,
// away from the active edge. Expected values are written out by hand.
module tb_reg_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_reg_id;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_reg_id;
  logic [31:0] lsu_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg_id;
  logic [31:0] md_data;
  logic [4:0]  write_reg_id;
  logic        write_reg_enable;
  logic [31:0] write_reg_data;
  logic [31:0] pending_mask;
  logic        drain_req;

  int checks;
  int failures;

  reg_writeback_arbiter #(
    .FIFO_DEPTH  (4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_reg_id      (alu_reg_id),
    .alu_data        (alu_data),
    .lsu_valid       (lsu_valid),
    .lsu_ready       (lsu_ready),
    .lsu_reg_id      (lsu_reg_id),
    .lsu_data        (lsu_data),
    .md_valid        (md_valid),
    .md_ready        (md_ready),
    .md_reg_id       (md_reg_id),
    .md_data         (md_data),
    .write_reg_id    (write_reg_id),
    .write_reg_enable(write_reg_enable),
    .write_reg_data  (write_reg_data),
    .pending_mask    (pending_mask),
    .drain_req       (drain_req)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive every producer input in one call.
  task automatic applyStimulus(input logic av, input logic [4:0] aid, input logic [31:0] ad,
                               input logic lv, input logic [4:0] lid, input logic [31:0] ld,
                               input logic mv, input logic [4:0] mid, input logic [31:0] mdd);
    alu_valid  = av;
    alu_reg_id = aid;
    alu_data   = ad;
    lsu_valid  = lv;
    lsu_reg_id = lid;
    lsu_data   = ld;
    md_valid   = mv;
    md_reg_id  = mid;
    md_data    = mdd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Check the whole write port at once.
  task automatic checkWrite(input string tag, input logic en, input logic [4:0] id, input logic [31:0] data);
    checkOutput({tag, "_en"}, 32'(write_reg_enable), 32'(en));
    if (en) begin
      checkOutput({tag, "_id"}, 32'(write_reg_id), 32'(id));
      checkOutput({tag, "_data"}, write_reg_data, data);
    end
  endtask

  initial begin
    logic [4:0] l_id;
    logic [4:0] m_id;
    logic       exp_lsu;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    $display("[TB] reset state");
    checkOutput("rst_wen", 32'(write_reg_enable), 32'd0);
    checkOutput("rst_wid", 32'(write_reg_id), 32'd0);
    checkOutput("rst_wdata", write_reg_data, 32'd0);
    checkOutput("rst_pending", pending_mask, 32'd0);
    checkOutput("rst_drain", 32'(drain_req), 32'd0);
    checkOutput("rst_lsu_ready", 32'(lsu_ready), 32'd1);
    checkOutput("rst_md_ready", 32'(md_ready), 32'd1);

    // Plain ALU write, one-cycle latency
    $display("[TB] ALU write");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkWrite("alu_w5", 1'b1, 5'd5, 32'hDEADBEEF);
    checkOutput("alu_pending", pending_mask, 32'd0);
    tick();
    checkWrite("alu_idle", 1'b0, 5'd0, 32'd0);

    // ALU and LSU together: ALU first, LSU queued then drained
    $display("[TB] ALU + LSU same cycle");
    applyStimulus(1'b1, 5'd7, 32'h22, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("mix_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkWrite("mix_w7", 1'b1, 5'd7, 32'h22);
    checkOutput("mix_pending_q", pending_mask, 32'h8);
    tick();
    checkWrite("mix_w3", 1'b1, 5'd3, 32'h11);
    checkOutput("mix_pending_empty", pending_mask, 32'd0);
    tick();
    checkWrite("mix_idle", 1'b0, 5'd0, 32'd0);

    // Contended enqueue with ALU holding the slot: grants L,M,L,M
    $display("[TB] round robin and starvation");
    l_id = 5'd1;
    m_id = 5'd2;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, l_id, 32'h100 + 32'(l_id), 1'b1, m_id, 32'h200 + 32'(m_id));
      #1;
      exp_lsu = ((k % 2) == 0);
      checkOutput($sformatf("rr_lsu_ready_%0d", k), 32'(lsu_ready), 32'(exp_lsu));
      checkOutput($sformatf("rr_md_ready_%0d", k), 32'(md_ready), 32'(!exp_lsu));
      tick();
      if (exp_lsu) l_id = l_id + 5'd2;
      else         m_id = m_id + 5'd2;
    end
    applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, l_id, 32'h100 + 32'(l_id), 1'b1, m_id, 32'h200 + 32'(m_id));
    #1;
    checkWrite("rr_alu_w10", 1'b1, 5'd10, 32'hA0);
    checkOutput("rr_pending_full", pending_mask, 32'h1E);
    checkOutput("rr_full_lsu_ready", 32'(lsu_ready), 32'd0);
    checkOutput("rr_full_md_ready", 32'(md_ready), 32'd0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("starve_7_drain", 32'(drain_req), 32'd0);
    tick();
    checkOutput("starve_8_drain", 32'(drain_req), 32'd1);
    tick();
    checkOutput("starve_hold_drain", 32'(drain_req), 32'd1);

    // ALU bubble: one pop, drain_req drops; full FIFO refuses LSU that cycle
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, l_id, 32'h100 + 32'(l_id), 1'b1, m_id, 32'h200 + 32'(m_id));
    #1;
    checkOutput("bubble_lsu_ready", 32'(lsu_ready), 32'd0);
    checkOutput("bubble_md_ready", 32'(md_ready), 32'd0);
    tick();
    checkWrite("bubble_w1", 1'b1, 5'd1, 32'h101);
    checkOutput("bubble_drain", 32'(drain_req), 32'd0);
    checkOutput("bubble_pending", pending_mask, 32'h1C);

    // The refused LSU result (id 5) is accepted the next cycle
    applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("retry_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("retry_pending", pending_mask, 32'h3C);
    tick();
    checkWrite("drain_w2", 1'b1, 5'd2, 32'h202);
    checkOutput("drain_pending_a", pending_mask, 32'h38);
    tick();
    checkWrite("drain_w3", 1'b1, 5'd3, 32'h103);
    tick();
    checkWrite("drain_w4", 1'b1, 5'd4, 32'h204);
    checkOutput("drain_pending_b", pending_mask, 32'h20);
    tick();
    checkWrite("drain_w5", 1'b1, 5'd5, 32'h105);
    checkOutput("drain_pending_c", pending_mask, 32'd0);
    tick();
    checkWrite("drain_idle", 1'b0, 5'd0, 32'd0);

    // Register 0 from ALU and LSU: no write, no enqueue
    $display("[TB] register 0");
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("r0_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("r0_alu_wen", 32'(write_reg_enable), 32'd0);
    checkOutput("r0_pending", pending_mask, 32'd0);
    tick();
    checkOutput("r0_no_pop_wen", 32'(write_reg_enable), 32'd0);

    // Duplicate ids: fill 2,9,2,4 then pop while re-offering id 9
    $display("[TB] duplicate ids and pop-while-full");
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd2, 32'h102, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd9, 32'h109, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd2, 32'h122, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd4, 32'h104, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("dup_pending_full", pending_mask, 32'h214);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h909, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("dup_full_lsu_ready", 32'(lsu_ready), 32'd0);
    tick();
    checkWrite("dup_pop_w2", 1'b1, 5'd2, 32'h102);
    checkOutput("dup_pending_pop1", pending_mask, 32'h214);
    checkOutput("dup_retry_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    checkWrite("dup_pop_w9", 1'b1, 5'd9, 32'h109);
    checkOutput("dup_pending_pop2", pending_mask, 32'h214);

    // Reset with three queued entries and a write on the port
    $display("[TB] reset mid-flight");
    rst = 1'b1;
    applyStimulus(1'b1, 5'd12, 32'hCAFE, 1'b1, 5'd6, 32'h106, 1'b0, 5'd0, 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("rst2_wen", 32'(write_reg_enable), 32'd0);
    checkOutput("rst2_wid", 32'(write_reg_id), 32'd0);
    checkOutput("rst2_wdata", write_reg_data, 32'd0);
    checkOutput("rst2_pending", pending_mask, 32'd0);
    checkOutput("rst2_drain", 32'(drain_req), 32'd0);
    checkOutput("rst2_lsu_ready", 32'(lsu_ready), 32'd1);
    checkOutput("rst2_md_ready", 32'(md_ready), 32'd1);
    tick();
    checkOutput("rst2_no_pop_wen", 32'(write_reg_enable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
